// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes, receive response and baud helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic CHECK_ODD  = 1'b1;
    localparam logic CHECK_EVEN = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } uart_rx_rsp_t;

    function automatic int bps_div(input int clk_mhz, input int bps);
        return (clk_mhz * 1000000) / bps;
    endfunction

    // Parity bit a transmitter in the given mode appends to d.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus falling-edge detector; flops idle at 1.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rx_i,
    output logic rx_sync,
    output logic fall_pulse
);

    // [0] metastability stage, [1] synced value, [2] previous synced value
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= 3'b111;
        else          sync_q <= {sync_q[1:0], rx_i};
    end

    assign rx_sync    = sync_q[1];
    assign fall_pulse = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; mid-bit sampling with error flags.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each bit centre (adds 1 cycle of latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int   CLK_FREQ  = 50,
    parameter int   UART_BPS  = 9600,
    parameter logic CHECK_SEL = CHECK_ODD
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       u_rx_i,
    output logic [7:0] data_in_o,
    output logic       rx_valid_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_busy_o
);

    localparam int BPS_DR = bps_div(CLK_FREQ, UART_BPS);
    localparam int HALF   = BPS_DR / 2;
    localparam int CW     = $clog2(BPS_DR);
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Voting needs the sample after the centre, so the start decision slips one cycle
    localparam logic [CW-1:0] START_END = CW'(HALF - 1 + MAJ);
    localparam logic [CW-1:0] BIT_END   = CW'(BPS_DR - 1);
    localparam logic          ODD_MODE  = (CHECK_SEL != CHECK_EVEN);

    logic rx_sync;
    logic fall_pulse;
    logic bit_val;

    uart_rx_sync u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rx_i       (u_rx_i),
        .rx_sync    (rx_sync),
        .fall_pulse (fall_pulse)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous synced samples; the current rx_sync is the third vote
    logic [1:0] win_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) win_q <= 2'b11;
        else          win_q <= {win_q[0], rx_sync};
    end

    assign bit_val = (win_q[1] & win_q[0]) | (win_q[1] & rx_sync) | (win_q[0] & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    uart_rx_rsp_t  rsp_q, rsp_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            rsp_q     <= rsp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        rsp_d     = rsp_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall_pulse) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (cnt_q == START_END) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A high line at the start-bit centre was only a glitch
                    if (bit_val) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    par_err_d = (bit_val != parity_bit(shift_q, ODD_MODE));
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Re-arm at the stop-bit centre so back-to-back start edges are caught
                if (cnt_q == BIT_END) begin
                    cnt_d            = '0;
                    state_d          = IDLE;
                    busy_d           = 1'b0;
                    valid_d          = 1'b1;
                    rsp_d.data       = shift_q;
                    rsp_d.parity_err = par_err_q;
                    rsp_d.frame_err  = ~bit_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_in_o       = rsp_q.data;
    assign rx_valid_o      = valid_q;
    assign rx_parity_err_o = valid_q & rsp_q.parity_err;
    assign rx_frame_err_o  = valid_q & rsp_q.frame_err;
    assign rx_busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised/directed bench for uart_rx (odd and even parity instances on one line) against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int B    = 434;   // 50 MHz / 115200
    localparam int HALF = 217;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Cycles from driving the start edge to seeing rx_valid_o
    localparam int LAT = 2 + HALF + 10 * B + 1 + MAJ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       u_rx;
    logic [7:0] d_o, d_e;
    logic       v_o, pe_o, fe_o, b_o;
    logic       v_e, pe_e, fe_e, b_e;

    uart_rx #(.CLK_FREQ(50), .UART_BPS(115200), .CHECK_SEL(1'b1)) u_odd (
        .clk_i(clk), .rst_n_i(rst_n), .u_rx_i(u_rx), .data_in_o(d_o), .rx_valid_o(v_o),
        .rx_parity_err_o(pe_o), .rx_frame_err_o(fe_o), .rx_busy_o(b_o)
    );

    uart_rx #(.CLK_FREQ(50), .UART_BPS(115200), .CHECK_SEL(1'b0)) u_even (
        .clk_i(clk), .rst_n_i(rst_n), .u_rx_i(u_rx), .data_in_o(d_e), .rx_valid_o(v_e),
        .rx_parity_err_o(pe_e), .rx_frame_err_o(fe_e), .rx_busy_o(b_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         frame;
        int         bstart;
        int         vcyc;
        logic [7:0] data;
        bit         pe_odd;
        bit         pe_even;
        bit         fe;
    } exp_t;

    exp_t       q[$];
    logic [7:0] rx_log[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         last_fall = 0;
    int         n_valid = 0;
    int         cap_cyc = 0;
    logic [7:0] cap_data = '0;
    logic [1:0] cap_o = '0;
    logic [1:0] cap_e = '0;
    logic [7:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Per-cycle compare of both instances against the frame queue
    exp_t h;
    logic ev, eb, epo, epe, efe;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                q.delete();
                last_data = '0;
                check("reset_odd",  {v_o, pe_o, fe_o, b_o, d_o}, 32'h0);
                check("reset_even", {v_e, pe_e, fe_e, b_e, d_e}, 32'h0);
            end else begin
                ev = 0; eb = 0; epo = 0; epe = 0; efe = 0;
                if (q.size() != 0) begin
                    h  = q[0];
                    eb = (cyc >= h.bstart) && (cyc < h.vcyc);
                    if (cyc == h.vcyc) begin
                        void'(q.pop_front());
                        if (h.frame) begin
                            ev = 1; epo = h.pe_odd; epe = h.pe_even; efe = h.fe;
                            last_data = h.data;
                        end
                    end
                end
                check("odd_outputs",  {v_o, pe_o, fe_o, b_o, d_o}, {ev, epo, efe, eb, last_data});
                check("even_outputs", {v_e, pe_e, fe_e, b_e, d_e}, {ev, epe, efe, eb, last_data});
                if (v_o) begin
                    n_valid++;
                    cap_cyc  = cyc;
                    cap_data = d_o;
                    cap_o    = {pe_o, fe_o};
                    rx_log.push_back(d_o);
                end
                if (v_e) cap_e = {pe_e, fe_e};
            end
        end
    end

    // Drives one frame; abort_at >= 0 stops after that many cycles. gmask flips data bit i for one cycle at its centre.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int abort_at, input logic [7:0] gmask);
        logic [10:0] bits;
        exp_t        e;
        int          n, ones, gi;
        logic        g;
        bits = {s, p, d, 1'b0};
        ones = $countones(d) + int'(p);
        n    = 0;
        for (int j = 0; j < 11; j++) begin
            for (int k = 0; k < B; k++) begin
                if (n == abort_at) return;
                @(negedge clk);
                if (n == 0) begin
                    last_fall = cyc;
                    e.frame   = 1'b1;
                    e.bstart  = cyc + 3;
                    e.vcyc    = cyc + LAT;
                    e.data    = d;
                    e.pe_odd  = (ones % 2 == 0);
                    e.pe_even = (ones % 2 == 1);
                    e.fe      = ~s;
                    q.push_back(e);
                end
                gi   = (j >= 1 && j <= 8) ? j - 1 : 0;
                g    = (j >= 1 && j <= 8 && k == HALF) ? gmask[gi] : 1'b0;
                u_rx = bits[j] ^ g;
                n++;
            end
        end
    endtask

    // Low pulse shorter than half a bit: busy for the start check only, no frame
    task automatic low_glitch(input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                e.frame = 1'b0; e.bstart = cyc + 3; e.vcyc = cyc + 3 + HALF + MAJ;
                e.data = '0; e.pe_odd = 0; e.pe_even = 0; e.fe = 0;
                q.push_back(e);
            end
            u_rx = 1'b0;
        end
        @(negedge clk);
        u_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            u_rx = 1'b1;
        end
    endtask

    int         nv, sz;
    logic [7:0] r1, r2, r3, rd;
    logic       rp, rs;
    initial begin
        rst_n = 1'b0;
        u_rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        send_frame(8'h55, 1'b1, 1'b1, -1, 8'h00);
        idle(5);
        check("t55_data", cap_data, 8'h55);
        check("t55_odd_flags", cap_o, 2'b00);
        check("t55_even_flags", cap_e, 2'b10);
        check("t55_latency", cap_cyc - last_fall, 4560 + MAJ);

        send_frame(8'hA3, 1'b0, 1'b1, -1, 8'h00);
        idle(5);
        check("tA3_data", cap_data, 8'hA3);
        check("tA3_odd_flags", cap_o, 2'b10);
        check("tA3_even_flags", cap_e, 2'b00);

        send_frame(8'h0F, 1'b1, 1'b0, -1, 8'h00);
        nv = n_valid;
        repeat (5 * 11 * B) @(negedge clk);
        idle(20);
        check("t0F_data", cap_data, 8'h0F);
        check("t0F_odd_flags", cap_o, 2'b01);
        check("break_no_frames", n_valid - nv, 0);

        nv = n_valid;
        low_glitch(100);
        idle(400);
        check("glitch_no_frame", n_valid - nv, 0);
        send_frame(8'h3C, 1'b1, 1'b1, -1, 8'h00);
        idle(5);
        check("t3C_data", cap_data, 8'h3C);
        check("t3C_odd_flags", cap_o, 2'b00);

        sz = rx_log.size();
        send_frame(8'h00, 1'b1, 1'b1, -1, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b1, -1, 8'h00);
        send_frame(8'h81, 1'b1, 1'b1, -1, 8'h00);
        idle(5);
        check("b2b_count", rx_log.size() - sz, 3);
        check("b2b_first", rx_log[sz], 8'h00);
        check("b2b_second", rx_log[sz + 1], 8'hFF);
        check("b2b_third", rx_log[sz + 2], 8'h81);

        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        send_frame(r1, ~^r1, 1'b1, -1, 8'h00);
        send_frame(r2, ~^r2, 1'b1, 5 * B + 100, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        u_rx  = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("post_reset_data", d_o, 8'h00);
        check("post_reset_busy", b_o, 1'b0);
        send_frame(r3, ~^r3, 1'b1, -1, 8'h00);
        idle(5);
        check("post_reset_frame", cap_data, r3);

        rd = 8'($urandom);
        rp = (~^rd) ^ 1'($urandom_range(0, 1));
        rs = ($urandom_range(0, 3) != 0);
        send_frame(rd, rp, rs, -1, 8'h00);
        idle($urandom_range(1, 40));

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h96, 1'b1, 1'b1, -1, 8'hFF);
        idle(5);
        check("maj_96_data", cap_data, 8'h96);
        check("maj_96_flags", cap_o, 2'b00);
`endif

        idle(10);
        check("model_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
